// File: rtl/debug_halt_ctrl_if.sv
// Run-control bundle between the debug register block / core and the halt controller.
// The master drives debug commands plus the core PC; the slave returns the freeze controls.
interface debug_halt_ctrl_if #(
  parameter int STAGES = 4,
  parameter int ADDR_W = 32
);
  logic              debug_en;
  logic              halt_req;
  logic              resume_req;
  logic              step_req;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc;

  logic [STAGES-1:0] enable_ext;
  logic              enable_pc_ext;
  logic              halted;
  logic              tx_flag;
  logic [1:0]        cause;

  modport master (
    output debug_en, halt_req, resume_req, step_req, bp_en, bp_addr, pc,
    input  enable_ext, enable_pc_ext, halted, tx_flag, cause
  );

  modport slave (
    input  debug_en, halt_req, resume_req, step_req, bp_en, bp_addr, pc,
    output enable_ext, enable_pc_ext, halted, tx_flag, cause
  );
endinterface

// File: rtl/debug_halt_ctrl.sv
// Debug run-control: turns halt/resume/step commands and a PC breakpoint into pipeline freeze
// enables, draining in-flight instructions before reporting the core as halted.
module debug_halt_ctrl #(
  parameter int STAGES = 4,
  parameter int ADDR_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  debug_halt_ctrl_if.slave dbg
);

  localparam int CNT_W = (STAGES > 2) ? $clog2(STAGES) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(STAGES - 1);
  localparam logic [STAGES-1:0] EN_DRAIN   = ~STAGES'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HALT = 2'd1,
    CAUSE_BP   = 2'd2,
    CAUSE_STEP = 2'd3
  } cause_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cause_e            cause_q, cause_d;
  logic              bp_skip_q, bp_skip_d;
  logic [STAGES-1:0] en_q, en_d;
  logic              pc_en_q, pc_en_d;
  logic              halted_q, halted_d;
  logic              tx_q, tx_d;

  logic [ADDR_W-1:0] pc_w;
  logic [ADDR_W-1:0] bp_w;
  logic              bp_match;
  logic              bp_hit;

  assign pc_w     = dbg.pc;
  assign bp_w     = dbg.bp_addr;
  assign bp_match = (pc_w == bp_w);
  // bp_skip lets the core step off the address it last stopped on without re-triggering.
  assign bp_hit   = dbg.bp_en & bp_match & ~bp_skip_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    bp_skip_d = bp_match ? bp_skip_q : 1'b0;

    if (!dbg.debug_en) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (dbg.halt_req) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LOAD;
            cause_d = CAUSE_HALT;
          end else if (bp_hit) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LOAD;
            cause_d = CAUSE_BP;
          end
        end
        ST_DRAIN: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          if (dbg.resume_req || dbg.step_req) begin
            state_d = dbg.resume_req ? ST_RUN : ST_STEP;
            if (bp_match) begin
              bp_skip_d = 1'b1;
            end
          end
        end
        ST_STEP: begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
          cause_d = CAUSE_STEP;
        end
        default: state_d = ST_RUN;
      endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    en_d     = '1;
    pc_en_d  = 1'b1;
    halted_d = 1'b0;
    tx_d     = 1'b0;
    unique case (state_d)
      ST_DRAIN: begin
        en_d    = EN_DRAIN;
        pc_en_d = 1'b0;
      end
      ST_HALT: begin
        en_d     = '0;
        pc_en_d  = 1'b0;
        halted_d = 1'b1;
        tx_d     = (state_q != ST_HALT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      cause_q   <= CAUSE_NONE;
      bp_skip_q <= 1'b0;
      en_q      <= '1;
      pc_en_q   <= 1'b1;
      halted_q  <= 1'b0;
      tx_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      bp_skip_q <= bp_skip_d;
      en_q      <= en_d;
      pc_en_q   <= pc_en_d;
      halted_q  <= halted_d;
      tx_q      <= tx_d;
    end
  end

  assign dbg.enable_ext    = en_q;
  assign dbg.enable_pc_ext = pc_en_q;
  assign dbg.halted        = halted_q;
  assign dbg.tx_flag       = tx_q;
  assign dbg.cause         = cause_q;

  a_tx_only_when_halted : assert property (@(posedge clk_i) disable iff (!rst_ni)
    tx_q |-> halted_q);
  a_halted_is_frozen : assert property (@(posedge clk_i) disable iff (!rst_ni)
    halted_q |-> (en_q == '0 && !pc_en_q));

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Scoreboarded bench for debug_halt_ctrl: directed run-control scenarios followed by random
// command traffic, each cycle checked against a cycle-level behavioural model.
module tb_debug_halt_ctrl;
  localparam int STAGES = 4;
  localparam int ADDR_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_halt_ctrl_if #(.STAGES(STAGES), .ADDR_W(ADDR_W)) dif ();

  debug_halt_ctrl #(.STAGES(STAGES), .ADDR_W(ADDR_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .dbg    (dif.slave)
  );

  typedef struct {
    logic [3:0] en;
    logic       pc_en;
    logic       halted;
    logic       tx;
    logic [1:0] cause;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [31:0] pc_v   = 32'h30;
  logic [31:0] bp_v   = 32'h40;
  bit          bpen_v = 1'b0;

  // Model: the core is either running, draining for a number of cycles, halted,
  // or spending one free-running cycle on a single step.
  bit m_halted, m_step, m_tx, m_skip;
  int m_drain, m_cause;

  function automatic void model_reset();
    m_halted = 0; m_step = 0; m_tx = 0; m_skip = 0; m_drain = 0; m_cause = 0;
  endfunction

  function automatic void model_step(bit en, bit hreq, bit rreq, bit sreq);
    bit match    = (pc_v == bp_v);
    bit hit      = bpen_v && match && !m_skip;
    bit new_skip = match ? m_skip : 1'b0;
    m_tx = 0;
    if (!en) begin
      m_halted = 0; m_step = 0; m_drain = 0;
    end else if (m_halted) begin
      if (rreq || sreq) begin
        m_halted = 0;
        m_step   = !rreq;
        if (match) new_skip = 1;
      end
    end else if (m_step) begin
      m_step = 0; m_drain = STAGES - 1; m_cause = 3;
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) begin m_halted = 1; m_tx = 1; end
    end else if (hreq) begin
      m_drain = STAGES - 1; m_cause = 1;
    end else if (hit) begin
      m_drain = STAGES - 1; m_cause = 2;
    end
    m_skip = new_skip;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.en     = (m_drain > 0) ? 4'b1110 : (m_halted ? 4'b0000 : 4'b1111);
    e.pc_en  = (m_drain == 0) && !m_halted;
    e.halted = m_halted;
    e.tx     = m_tx;
    e.cause  = 2'(m_cause);
    return e;
  endfunction

  // One cycle of stimulus: drive inputs at the falling edge and queue the expected response.
  task automatic tick(bit en, bit hreq, bit rreq, bit sreq);
    @(negedge clk);
    dif.debug_en   = en;
    dif.halt_req   = hreq;
    dif.resume_req = rreq;
    dif.step_req   = sreq;
    dif.bp_en      = bpen_v;
    dif.bp_addr    = bp_v;
    dif.pc         = pc_v;
    if (rst_n) model_step(en, hreq, rreq, sreq);
    else       model_reset();
    sb_q.push_back(model_out());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0);
  endtask

  task automatic hold_reset(int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (dif.enable_ext !== e.en || dif.enable_pc_ext !== e.pc_en || dif.halted !== e.halted ||
          dif.tx_flag !== e.tx || dif.cause !== e.cause) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got en=%b pc_en=%b halted=%b tx=%b cause=%0d, expected en=%b pc_en=%b halted=%b tx=%b cause=%0d",
                 cyc, dif.enable_ext, dif.enable_pc_ext, dif.halted, dif.tx_flag, dif.cause,
                 e.en, e.pc_en, e.halted, e.tx, e.cause);
      end else begin
        $display("cycle %0d: en=%b pc_en=%b halted=%b tx=%b cause=%0d ok",
                 cyc, dif.enable_ext, dif.enable_pc_ext, dif.halted, dif.tx_flag, dif.cause);
      end
    end
  end

  initial begin
    dif.debug_en = 0; dif.halt_req = 0; dif.resume_req = 0; dif.step_req = 0;
    dif.bp_en = 0; dif.bp_addr = 32'h40; dif.pc = 32'h30;
    model_reset();
    hold_reset(3);

    // Plain halt, then single step, then resume+step together (resume wins).
    idle(5);
    tick(1, 1, 0, 0);
    idle(6);
    tick(1, 0, 0, 1);
    idle(6);
    tick(1, 0, 1, 1);
    idle(3);

    // Breakpoint at 0x40 with a ramping PC, resume in place, re-hit later.
    bpen_v = 1;
    for (int i = 0; i < 4; i++) begin pc_v = 32'h30 + 32'(4 * i); tick(1, 0, 0, 0); end
    pc_v = 32'h40;
    idle(6);
    tick(1, 0, 1, 0);
    idle(3);
    pc_v = 32'h44; tick(1, 0, 0, 0);
    pc_v = 32'h48; tick(1, 0, 0, 0);
    pc_v = 32'h40;
    idle(6);
    tick(1, 0, 0, 1);
    idle(6);
    tick(1, 0, 1, 0);
    pc_v = 32'h44; tick(1, 0, 0, 0);

    // halt_req together with a breakpoint hit: halt_req cause wins.
    pc_v = 32'h40;
    tick(1, 1, 0, 0);
    idle(6);
    tick(1, 0, 1, 0);
    pc_v = 32'h44;
    idle(2);

    // Drop debug_en mid-drain, and a halt request while debug is disabled.
    tick(1, 1, 0, 0);
    idle(1);
    tick(0, 0, 0, 0);
    idle(3);
    tick(0, 1, 0, 0);
    idle(3);

    // Asynchronous reset while halted.
    tick(1, 1, 0, 0);
    idle(6);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dif.enable_ext !== 4'b1111 || dif.enable_pc_ext !== 1'b1 || dif.halted !== 1'b0 ||
        dif.tx_flag !== 1'b0 || dif.cause !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: got en=%b pc_en=%b halted=%b tx=%b cause=%0d, expected en=1111 pc_en=1 halted=0 tx=0 cause=0",
               dif.enable_ext, dif.enable_pc_ext, dif.halted, dif.tx_flag, dif.cause);
    end else begin
      $display("async reset in HALT: outputs at reset values ok");
    end
    hold_reset(2);

    // Random command traffic around the breakpoint address.
    pc_v = 32'h30;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 1) pc_v = (pc_v >= 32'h50) ? 32'h30 : pc_v + 32'd4;
      bpen_v = ($urandom_range(0, 9) != 0);
      tick($urandom_range(0, 29) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    idle(2);
    @(posedge clk);
    #2;

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
